// File: rtl/lut_cfg_pkg.sv
// Shared types for the LUT configuration loader: controller state encoding
// and the default word/checksum width.
package lut_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_e;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/cfg_sum_acc.sv
// Modular accumulator: clear wins over enable, sum wraps at 2^W.
module cfg_sum_acc #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);
  logic [W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = '0;
    else if (en_i) sum_d = sum_q + data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/lut_config_loader.sv
// Streams configuration words into a daisy-chained LUT shift chain and can
// recirculate the chain once to check a read-back checksum.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = CSUM_W,
  parameter int CHAIN_WORDS  = 16,
  parameter int CNT_W        = $clog2(CHAIN_WORDS + 1)
) (
  input  logic                    config_clk,
  input  logic                    config_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    verify_en,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    chain_en,
  output logic [CONFIG_WIDTH-1:0] chain_data,
  input  logic [CONFIG_WIDTH-1:0] chain_return,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_WORDS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    vfy_q, vfy_d;
  logic                    err_q, err_d;
  logic                    sum_clr, ld_en, rd_en;
  logic [CONFIG_WIDTH-1:0] ld_sum, rd_sum, rd_final;

  // Read-back sum including the word on chain_return this cycle.
  assign rd_final = rd_sum + chain_return;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vfy_d      = vfy_q;
    err_d      = err_q;
    sum_clr    = 1'b0;
    ld_en      = 1'b0;
    rd_en      = 1'b0;
    s_ready    = 1'b0;
    chain_en   = 1'b0;
    chain_data = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
          vfy_d   = verify_en;
          sum_clr = 1'b1;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        s_ready    = (cnt_q < FULL);
        chain_data = s_data;
        chain_en   = s_valid & s_ready;
        ld_en      = chain_en;
        if (chain_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = vfy_q ? VERIFY : DONE;
          end
        end
      end
      VERIFY: begin
        busy       = 1'b1;
        chain_en   = 1'b1;
        chain_data = chain_return;
        rd_en      = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          err_d   = (rd_final != ld_sum);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides start and handshake bookkeeping; the combinational
    // chain_en above still lets the current word shift in.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      sum_clr = 1'b0;
    end
  end

  always_ff @(posedge config_clk or posedge config_rst) begin
    if (config_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vfy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vfy_q   <= vfy_d;
      err_q   <= err_d;
    end
  end

  assign error = err_q;

  cfg_sum_acc #(.W(CONFIG_WIDTH)) u_load_sum (
    .clk_i  (config_clk),
    .rst_i  (config_rst),
    .clr_i  (sum_clr),
    .en_i   (ld_en),
    .data_i (s_data),
    .sum_o  (ld_sum)
  );

  cfg_sum_acc #(.W(CONFIG_WIDTH)) u_read_sum (
    .clk_i  (config_clk),
    .rst_i  (config_rst),
    .clr_i  (sum_clr),
    .en_i   (rd_en),
    .data_i (chain_return),
    .sum_o  (rd_sum)
  );
endmodule

// File: tb/tb_lut_config_loader.sv
// Randomized bench for lut_config_loader with a 4-deep behavioural chain and
// a word-queue/checksum reference model.
module tb_lut_config_loader;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          config_clk = 1'b0;
  logic          config_rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, verify_en = 1'b0;
  logic [CW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, chain_en, busy, done, error;
  logic [CW-1:0] chain_data, chain_return;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int ret_idx = -1;
  bit corrupt_on = 1'b0;
  logic [CW-1:0] chain [NW];

  lut_config_loader #(.CONFIG_WIDTH(CW), .CHAIN_WORDS(NW)) dut (
    .config_clk   (config_clk),
    .config_rst   (config_rst),
    .start        (start),
    .abort        (abort),
    .verify_en    (verify_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .chain_en     (chain_en),
    .chain_data   (chain_data),
    .chain_return (chain_return),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 config_clk = ~config_clk;

  // Behavioural chain: head at index 0, tail (oldest word) at NW-1.
  assign chain_return = chain[NW-1] ^ ((corrupt_on && ret_idx == 1) ? 8'h01 : 8'h00);

  always @(posedge config_clk) begin
    if (chain_en) begin
      for (int i = NW - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= chain_data;
      en_cnt   <= en_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge config_clk);
    #1;
  endtask

  task automatic run_load(input bit v, input bit corrupt, input int abort_after, input int rst_at);
    logic [CW-1:0] w [NW];
    logic [CW-1:0] exp_ret, ld_sum, rd_sum;
    int idx, cyc, en0;
    for (int i = 0; i < NW; i++) w[i] = CW'($urandom);
    ld_sum = '0;
    for (int i = 0; i < NW; i++) ld_sum = ld_sum + w[i];
    corrupt_on = corrupt;
    start = 1'b1; verify_en = v; s_valid = 1'b0; abort = 1'b0;
    step();
    start = 1'b0; verify_en = 1'($urandom);
    #3;
    chk("load_busy", {31'd0, busy}, 1);
    chk("load_done", {31'd0, done}, 0);
    chk("err_clr", {31'd0, error}, 0);
    en0 = en_cnt;
    idx = 0; cyc = 0;
    while (idx < NW && cyc < 100) begin
      if (idx == abort_after) begin
        abort = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = w[idx];
        #3;
        chk("abort_shift", {31'd0, chain_en}, 1);
        step();
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        chk("abort_pulses", en_cnt - en0, abort_after + 1);
        #3;
        chk("abort_ready", {31'd0, s_ready}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        step();
        return;
      end
      s_valid = 1'($urandom_range(0, 1));
      s_data  = s_valid ? w[idx] : CW'($urandom);
      #3;
      chk("load_ready", {31'd0, s_ready}, 1);
      chk("load_en", {31'd0, chain_en}, {31'd0, s_valid});
      if (s_valid) chk("load_data", {24'd0, chain_data}, {24'd0, w[idx]});
      if (s_valid) idx++;
      cyc++;
      step();
    end
    if (idx < NW) chk("load_timeout", idx, NW);
    s_valid = 1'b0;
    chk("load_pulses", en_cnt - en0, NW);
    rd_sum = '0;
    if (v) begin
      for (int k = 0; k < NW; k++) begin
        ret_idx = k;
        exp_ret = w[k] ^ ((corrupt && k == 1) ? 8'h01 : 8'h00);
        rd_sum  = rd_sum + exp_ret;
        #3;
        chk("vfy_en", {31'd0, chain_en}, 1);
        chk("vfy_ready", {31'd0, s_ready}, 0);
        chk("vfy_busy", {31'd0, busy}, 1);
        chk("vfy_data", {24'd0, chain_data}, {24'd0, exp_ret});
        if (k == rst_at) begin
          #1 config_rst = 1'b1;
          #1;
          chk("rst_en", {31'd0, chain_en}, 0);
          chk("rst_busy", {31'd0, busy}, 0);
          chk("rst_done", {31'd0, done}, 0);
          chk("rst_err", {31'd0, error}, 0);
          ret_idx = -1;
          step();
          config_rst = 1'b0;
          for (int j = 0; j < 3; j++) begin
            #3;
            chk("post_rst_busy", {31'd0, busy}, 0);
            chk("post_rst_done", {31'd0, done}, 0);
            chk("post_rst_ready", {31'd0, s_ready}, 0);
            step();
          end
          return;
        end
        step();
      end
      ret_idx = -1;
    end
    #3;
    chk("fin_done", {31'd0, done}, 1);
    chk("fin_busy", {31'd0, busy}, 0);
    chk("fin_ready", {31'd0, s_ready}, 0);
    chk("fin_en", {31'd0, chain_en}, 0);
    chk("fin_err", {31'd0, error}, {31'd0, (v && rd_sum != ld_sum)});
    if (v && !corrupt)
      for (int i = 0; i < NW; i++)
        chk("chain_kept", {24'd0, chain[NW-1-i]}, {24'd0, w[i]});
    step();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) chain[i] = '0;
    #3;
    chk("rst_ready", {31'd0, s_ready}, 0);
    chk("rst_chain_en", {31'd0, chain_en}, 0);
    chk("rst_chain_data", {24'd0, chain_data}, 0);
    chk("rst_busy0", {31'd0, busy}, 0);
    chk("rst_done0", {31'd0, done}, 0);
    chk("rst_error0", {31'd0, error}, 0);
    step(); step();
    config_rst = 1'b0;
    step();
    #3 chk("idle_busy", {31'd0, busy}, 0);
    step();

    run_load(1'b0, 1'b0, -1, -1);
    run_load(1'b1, 1'b0, -1, -1);
    run_load(1'b1, 1'b1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("err_sticky", {31'd0, error}, 1);
      chk("done_hold", {31'd0, done}, 1);
      step();
    end
    run_load(1'b0, 1'b0, -1, -1);
    run_load(1'b0, 1'b0, 2, -1);
    run_load(1'b0, 1'b0, -1, -1);
    run_load(1'b1, 1'b0, -1, 1);
    for (int i = 0; i < 8; i++)
      run_load(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
Sequences stream-style configuration of a daisy-chained LUT configuration shift chain. It accepts configuration words over a valid/ready stream and drives the chain's enable and data inputs, counting words until the whole chain is loaded. An optional verify pass recirculates the chain's tail output back into its head, which restores the loaded contents, and compares a checksum of the read-back words against the loaded words. It sits between the bitstream source (host or ROM streamer) and the first LUT's config_in/config_en.

Parameters:
CONFIG_WIDTH, 8, chain word width; matches the LUT configuration word width
CHAIN_WORDS, 16, total words in the chain (sum over LUTs of MEM_SIZE/CONFIG_WIDTH); must be >= 1
CNT_W, $clog2(CHAIN_WORDS+1), word-counter width (derived; do not override)

Ports:
config_clk  in  1  single clock for controller and chain
config_rst  in  1  asynchronous, active-high reset
start  in  1  begin a load; sampled in IDLE or DONE, ignored in LOAD/VERIFY
abort  in  1  synchronous abort from any state to IDLE
verify_en  in  1  sampled together with start; selects the verify pass after load
s_data  in  CONFIG_WIDTH  configuration word
s_valid  in  1  s_data valid
s_ready  out  1  controller accepts s_data
chain_en  out  1  to the first LUT's config_en
chain_data  out  CONFIG_WIDTH  to the first LUT's config_in
chain_return  in  CONFIG_WIDTH  from the last LUT's config_out
busy  out  1  high in LOAD or VERIFY
done  out  1  level; high in DONE
error  out  1  verify checksum mismatch; sticky until next start

Behaviour:
- Reset (async, immediate, no clock edge required): state=IDLE, word count=0, both checksums=0, verify flag=0; s_ready=0, chain_en=0, chain_data=0, busy=0, done=0, error=0.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE/DONE + start: next edge -> LOAD; clear count, both checksums and error; latch verify_en. done drops in the first LOAD cycle.
- LOAD: s_ready=1 while count < CHAIN_WORDS. chain_en = s_valid & s_ready and chain_data = s_data (combinational, zero latency). Each handshake increments count and adds s_data to load_sum (mod 2^CONFIG_WIDTH).
- LOAD exit: at the edge of the handshake that brings count to CHAIN_WORDS, go to VERIFY if the latched verify flag is 1, else DONE; reset count to 0. s_ready is 0 from the next cycle. s_valid without s_ready has no effect.
- VERIFY: chain_en=1 every cycle and chain_data=chain_return (recirculate). Add chain_return to read_sum each cycle. After exactly CHAIN_WORDS cycles go to DONE. Chain contents after VERIFY equal the contents after LOAD.
- VERIFY exit: at that same edge, error <= (read_sum_final != load_sum), where read_sum_final includes the last word.
- Word order: the first word loaded is the first word returned on chain_return in VERIFY.
- DONE: done=1, outputs otherwise idle; hold until start or abort. error is only updated in VERIFY; with verify off it stays 0.
- abort: highest priority over start and handshake in the same cycle. At the next edge go to IDLE and clear count; done=0, error=0. The word presented in the abort cycle is still shifted if the handshake occurs (chain_en is combinational). Chain contents are partial and undefined.
- start and abort in the same cycle: abort wins.
- Outside LOAD/VERIFY: chain_en=0 and chain_data=0.

Decomposition:
- Package lut_cfg_pkg holds the state enum (IDLE, LOAD, VERIFY, DONE) and the checksum-width localparam.
- One sub-module, cfg_sum_acc: clear/enable/data-in modular accumulator, instantiated twice (load_sum, read_sum).
- FSM, counter and output muxing live in lut_config_loader.

Test Plan:
1. CONFIG_WIDTH=8, CHAIN_WORDS=4, verify_en=0, words 0x11,0x22,0x33,0x44 with s_valid held high -> exactly 4 chain_en pulses carrying those values; done=1 on the cycle after the 4th handshake; busy=0; s_ready=0 from then on.
2. Same words with verify_en=1 and a behavioural 4-deep chain model -> 4 VERIFY cycles with chain_data=0x11,0x22,0x33,0x44; then done=1, error=0; chain model still holds the original contents.
3. As test 2, but the model XORs 0x01 into the 2nd returned word -> done=1, error=1; error stays 1 until the next start, which clears it.
4. s_valid pattern 1,0,0,1,1,0,1 -> chain_en only on handshake cycles; LOAD ends after the 4th accepted word, with no extra or missing shifts.
5. abort after 2 accepted words -> IDLE next edge; s_ready=0, done=0. A new start then accepts 4 full words and the count restarts from 0.
6. Assert config_rst mid-VERIFY, between clock edges -> chain_en, busy, done and error go to 0 immediately. After release, the block stays in IDLE until start.
